// File: rtl/mips8_pkg.sv
// Shared encodings for the multicycle MIPS8 controller: FSM states, opcodes and mux selects.
// The ADDI states exist only when MIPS8_ADDI_EN is defined.
package mips8_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_ONE   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12
`ifdef MIPS8_ADDI_EN
    ,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
`endif
  } state_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [3:0] irwrite;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Dispatch out of DECODE; unrecognised opcodes restart the fetch.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LB, OP_SB: nxt = MEMADR;
      OP_RTYPE:     nxt = RTYPEEX;
      OP_BEQ:       nxt = BEQEX;
      OP_J:         nxt = JEX;
`ifdef MIPS8_ADDI_EN
      OP_ADDI:      nxt = ADDIEX;
`endif
      default:      nxt = FETCH1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips8_controller.sv
// Moore control FSM for the byte-wide multicycle MIPS8 datapath (four-cycle instruction fetch).
// Define MIPS8_ADDI_EN to add the ADDIEX/ADDIWR states; otherwise ADDI decodes as illegal.
module mips8_controller
  import mips8_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       iord,
  output logic       regwrite,
  output logic       regdst,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [3:0] irwrite
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl    = CTRL_IDLE;
    state_d = FETCH1;
    case (state_q)
      FETCH1: begin
        ctrl.memread = 1'b1;
        ctrl.irwrite = 4'b0001;
        ctrl.alusrcb = ALUSRCB_ONE;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.pcwrite = 1'b1;
        state_d      = FETCH2;
      end
      FETCH2: begin
        ctrl.memread = 1'b1;
        ctrl.irwrite = 4'b0010;
        ctrl.alusrcb = ALUSRCB_ONE;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.pcwrite = 1'b1;
        state_d      = FETCH3;
      end
      FETCH3: begin
        ctrl.memread = 1'b1;
        ctrl.irwrite = 4'b0100;
        ctrl.alusrcb = ALUSRCB_ONE;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.pcwrite = 1'b1;
        state_d      = FETCH4;
      end
      FETCH4: begin
        ctrl.memread = 1'b1;
        ctrl.irwrite = 4'b1000;
        ctrl.alusrcb = ALUSRCB_ONE;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.pcwrite = 1'b1;
        state_d      = DECODE;
      end
      // Branch target is precomputed here while the register file is read.
      DECODE: begin
        ctrl.alusrcb = ALUSRCB_BRIMM;
        ctrl.aluop   = ALUOP_ADD;
        state_d      = decode_next(op);
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
        state_d      = (op == OP_LB) ? LBRD : SBWR;
      end
      LBRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        state_d      = LBWR;
      end
      LBWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        state_d       = FETCH1;
      end
      SBWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
        state_d       = FETCH1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
        state_d      = RTYPEWR;
      end
      RTYPEWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        state_d       = FETCH1;
      end
      BEQEX: begin
        ctrl.alusrca  = 1'b1;
        ctrl.alusrcb  = ALUSRCB_REG;
        ctrl.aluop    = ALUOP_SUB;
        ctrl.branch   = 1'b1;
        ctrl.pcsource = PCSRC_ALUOUT;
        state_d       = FETCH1;
      end
      JEX: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
        state_d       = FETCH1;
      end
`ifdef MIPS8_ADDI_EN
      ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
        state_d      = ADDIWR;
      end
      ADDIWR: begin
        ctrl.regwrite = 1'b1;
        state_d       = FETCH1;
      end
`endif
      default: begin
        state_d = FETCH1;
      end
    endcase
  end

  assign memread  = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign alusrca  = ctrl.alusrca;
  assign memtoreg = ctrl.memtoreg;
  assign iord     = ctrl.iord;
  assign regwrite = ctrl.regwrite;
  assign regdst   = ctrl.regdst;
  assign pcsource = ctrl.pcsource;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign irwrite  = ctrl.irwrite;

  // The only non-Moore output: a taken BEQ redirects the PC in BEQEX.
  assign pcen = ctrl.pcwrite | (ctrl.branch & zero);

endmodule

// File: tb/tb_mips8_controller.sv
// Scoreboard bench for mips8_controller: expected per-cycle outputs are queued per instruction.
// Honours MIPS8_ADDI_EN for the ADDI expectations.
module tb_mips8_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen;
  logic [1:0] pcsource, alusrcb, aluop;
  logic [3:0] irwrite;

  always #5 clk = ~clk;

  mips8_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .zero     (zero),
    .memread  (memread),
    .memwrite (memwrite),
    .alusrca  (alusrca),
    .memtoreg (memtoreg),
    .iord     (iord),
    .regwrite (regwrite),
    .regdst   (regdst),
    .pcen     (pcen),
    .pcsource (pcsource),
    .alusrcb  (alusrcb),
    .aluop    (aluop),
    .irwrite  (irwrite)
  );

  typedef enum int {
    T_F1, T_F2, T_F3, T_F4, T_DEC, T_MEMADR, T_LBRD, T_LBWR, T_SBWR,
    T_RTEX, T_RTWR, T_BEQEX, T_JEX, T_ADDIEX, T_ADDIWR
  } tst_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       pcen;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [3:0] irwrite;
  } outs_t;

  typedef struct {
    string tag;
    outs_t exp;
  } sb_t;

  sb_t   sb_q[$];
  tst_t  plan_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_cyc = 0;

  function automatic outs_t exp_of(input tst_t s, input logic z);
    outs_t e;
    e = '0;
    case (s)
      T_F1:     begin e.memread = 1'b1; e.irwrite = 4'b0001; e.alusrcb = 2'b01; e.pcen = 1'b1; end
      T_F2:     begin e.memread = 1'b1; e.irwrite = 4'b0010; e.alusrcb = 2'b01; e.pcen = 1'b1; end
      T_F3:     begin e.memread = 1'b1; e.irwrite = 4'b0100; e.alusrcb = 2'b01; e.pcen = 1'b1; end
      T_F4:     begin e.memread = 1'b1; e.irwrite = 4'b1000; e.alusrcb = 2'b01; e.pcen = 1'b1; end
      T_DEC:    begin e.alusrcb = 2'b11; end
      T_MEMADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      T_LBRD:   begin e.memread = 1'b1; e.iord = 1'b1; end
      T_LBWR:   begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
      T_SBWR:   begin e.memwrite = 1'b1; e.iord = 1'b1; end
      T_RTEX:   begin e.alusrca = 1'b1; e.aluop = 2'b10; end
      T_RTWR:   begin e.regwrite = 1'b1; e.regdst = 1'b1; end
      T_BEQEX:  begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsource = 2'b01; e.pcen = z; end
      T_JEX:    begin e.pcen = 1'b1; e.pcsource = 2'b10; end
      T_ADDIEX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      T_ADDIWR: begin e.regwrite = 1'b1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic make_plan(input logic [5:0] o);
    plan_q.delete();
    plan_q.push_back(T_F1);
    plan_q.push_back(T_F2);
    plan_q.push_back(T_F3);
    plan_q.push_back(T_F4);
    plan_q.push_back(T_DEC);
    case (o)
      6'b100000: begin plan_q.push_back(T_MEMADR); plan_q.push_back(T_LBRD); plan_q.push_back(T_LBWR); end
      6'b101000: begin plan_q.push_back(T_MEMADR); plan_q.push_back(T_SBWR); end
      6'b000000: begin plan_q.push_back(T_RTEX); plan_q.push_back(T_RTWR); end
      6'b000100: plan_q.push_back(T_BEQEX);
      6'b000010: plan_q.push_back(T_JEX);
`ifdef MIPS8_ADDI_EN
      6'b001000: begin plan_q.push_back(T_ADDIEX); plan_q.push_back(T_ADDIWR); end
`endif
      default: ;
    endcase
  endtask

  task automatic chk_vec(input string tag, input outs_t obs, input outs_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called on the falling edge: pop one expectation and check the exclusivity invariants.
  task automatic check_cycle();
    sb_t   item;
    outs_t obs;
    obs = {memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen,
           pcsource, alusrcb, aluop, irwrite};
    n_cyc++;
    if (sb_q.size() == 0) begin
      chk_bit("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      item = sb_q.pop_front();
      chk_vec(item.tag, obs, item.exp);
    end
    chk_bit("memread_and_memwrite", memread & memwrite, 1'b0);
    chk_bit("regwrite_and_memwrite", regwrite & memwrite, 1'b0);
    chk_bit("irwrite_onehot0", $onehot0(irwrite), 1'b1);
  endtask

  task automatic run_instr(input string label, input logic [5:0] o, input logic z,
                           input int abort_after);
    sb_t item;
    int  n;
    make_plan(o);
    op   = o;
    zero = z;
    foreach (plan_q[i]) begin
      item.tag = $sformatf("%s op=%b z=%b %s", label, o, z, plan_q[i].name());
      item.exp = exp_of(plan_q[i], z);
      sb_q.push_back(item);
    end
    n = (abort_after > 0) ? abort_after : plan_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle();
      if (abort_after > 0 && i == n - 1) reset_n = 1'b0;
      @(posedge clk);
      #1;
    end
    if (abort_after > 0) begin
      reset_n = 1'b1;
      sb_q.delete();
    end
    $display("txn %-8s op=%b zero=%b cycles=%0d compared=%0d mismatched=%0d",
             label, o, z, n, n_cmp, n_err);
  endtask

  logic [5:0] rand_ops [7];

  initial begin
    sb_t item;
    reset_n = 1'b0;
    op      = 6'b000000;
    zero    = 1'b0;

    // Reset held across three rising edges; FETCH1 visible during it.
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      item.tag = $sformatf("reset_cycle%0d", i);
      item.exp = exp_of(T_F1, 1'b0);
      sb_q.push_back(item);
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    $display("txn reset    held 3 cycles, released");

    run_instr("LB",      6'b100000, 1'b0, 0);
    run_instr("SB",      6'b101000, 1'b1, 0);
    run_instr("RTYPE",   6'b000000, 1'b0, 0);
    run_instr("BEQ_T",   6'b000100, 1'b1, 0);
    run_instr("BEQ_NT",  6'b000100, 1'b0, 0);
    run_instr("J",       6'b000010, 1'b0, 0);
    run_instr("ADDI",    6'b001000, 1'b0, 0);
    run_instr("ILLEGAL", 6'b111111, 1'b1, 0);
    run_instr("RT_ABRT", 6'b000000, 1'b0, 6);
    run_instr("RTYPE",   6'b000000, 1'b1, 0);

    rand_ops[0] = 6'b100000;
    rand_ops[1] = 6'b101000;
    rand_ops[2] = 6'b000000;
    rand_ops[3] = 6'b000100;
    rand_ops[4] = 6'b000010;
    rand_ops[5] = 6'b001000;
    rand_ops[6] = 6'b000000;
    while (n_cyc < 10000) begin
      int         k;
      logic [5:0] o;
      k = $urandom_range(0, 7);
      o = (k == 7) ? 6'($urandom_range(0, 63)) : rand_ops[k];
      run_instr("RAND", o, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
